// File: rtl/pipelined_bypass_subtractor_if.sv
// Operand/result stream bundle for pipelined_bypass_subtractor.
//
// Optional macro: PIPELINED_BYPASS_SUBTRACTOR_OVERFLOW_EN adds oOverflow.
//
// Signals (named from the subtractor's point of view):
//   iValid / oReady          operand beat handshake (producer -> unit)
//   iA, iB, iBorrow          minuend, subtrahend, borrow-in
//   oValid / iReady          result beat handshake (unit -> consumer)
//   oDiff, oBorrow           difference and borrow-out
//   oOverflow                signed overflow flag (optional)
// Modports: slave = subtractor side, master = producer/consumer side.
interface pipelined_bypass_subtractor_if #(
    parameter int unsigned ADDER_WIDTH = 32
);
    logic                   iValid;
    logic                   oReady;
    logic [ADDER_WIDTH-1:0] iA;
    logic [ADDER_WIDTH-1:0] iB;
    logic                   iBorrow;
    logic                   oValid;
    logic                   iReady;
    logic [ADDER_WIDTH-1:0] oDiff;
    logic                   oBorrow;
`ifdef PIPELINED_BYPASS_SUBTRACTOR_OVERFLOW_EN
    logic                   oOverflow;

    modport slave (
        input  iValid, iA, iB, iBorrow, iReady,
        output oReady, oValid, oDiff, oBorrow, oOverflow
    );
    modport master (
        output iValid, iA, iB, iBorrow, iReady,
        input  oReady, oValid, oDiff, oBorrow, oOverflow
    );
`else
    modport slave (
        input  iValid, iA, iB, iBorrow, iReady,
        output oReady, oValid, oDiff, oBorrow
    );
    modport master (
        output iValid, iA, iB, iBorrow, iReady,
        input  oReady, oValid, oDiff, oBorrow
    );
`endif
endinterface

// File: rtl/pipelined_bypass_subtractor.sv
// Streaming N-bit subtractor: oDiff = iA - iB - iBorrow, one BLOCK_WIDTH block
// resolved per pipeline stage with block-level borrow bypass. Throughput of one
// beat per cycle, valid/ready on both sides, fully registered outputs.
//
// Optional macro: PIPELINED_BYPASS_SUBTRACTOR_OVERFLOW_EN adds a registered
// signed-overflow flag (bus.oOverflow) aligned with oDiff.
//
// Ports:
//   iClk   clock, rising edge
//   iRstn  asynchronous active-low reset; discards all in-flight beats
//   bus    pipelined_bypass_subtractor_if.slave (operand/result streams)
module pipelined_bypass_subtractor #(
    parameter int unsigned ADDER_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH = 8
) (
    input logic                          iClk,
    input logic                          iRstn,
    pipelined_bypass_subtractor_if.slave bus
);

    localparam int unsigned STAGES = ADDER_WIDTH / BLOCK_WIDTH;
    localparam int unsigned MSB    = ADDER_WIDTH - 1;

    if ((BLOCK_WIDTH == 0) || (BLOCK_WIDTH > ADDER_WIDTH) ||
        ((ADDER_WIDTH % BLOCK_WIDTH) != 0)) begin : gBadCfg
        $error("ADDER_WIDTH must be a non-zero multiple of BLOCK_WIDTH");
    end

    // Subtraction is done as A + ~B + ~borrowIn, so the pipeline carries ~B and
    // a true carry; the borrow-out is the inverted carry of the top block.
    logic [STAGES-1:0]      validQ;
    logic [STAGES-1:0]      carryQ;
    logic [STAGES-1:0]      adv;
    logic [ADDER_WIDTH-1:0] diffQ [STAGES];
    logic [ADDER_WIDTH-1:0] aQ    [STAGES];
    logic [ADDER_WIDTH-1:0] nbQ   [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic [ADDER_WIDTH-1:0] aIn;
        logic [ADDER_WIDTH-1:0] nbIn;
        logic [ADDER_WIDTH-1:0] diffIn;
        logic [ADDER_WIDTH-1:0] diffNext;
        logic                   cIn;
        logic                   vIn;
        logic [BLOCK_WIDTH-1:0] aBlk;
        logic [BLOCK_WIDTH-1:0] nbBlk;
        logic [BLOCK_WIDTH-1:0] sumBlk;
        logic                   rippleCarry;
        logic                   cOut;

        if (k == 0) begin : gIn
            assign aIn    = bus.iA;
            assign nbIn   = ~bus.iB;
            assign cIn    = ~bus.iBorrow;
            assign vIn    = bus.iValid;
            assign diffIn = '0;
        end else begin : gIn
            assign aIn    = aQ[k-1];
            assign nbIn   = nbQ[k-1];
            assign cIn    = carryQ[k-1];
            assign vIn    = validQ[k-1];
            assign diffIn = diffQ[k-1];
        end

        // Unrolled form of adv_k = ~valid_k | adv_{k+1}: a stage may move
        // whenever any stage at or above it is empty or the consumer is ready.
        assign adv[k] = bus.iReady | ~(&validQ[STAGES-1:k]);

        always_comb begin
            aBlk   = aIn[k*BLOCK_WIDTH +: BLOCK_WIDTH];
            nbBlk  = nbIn[k*BLOCK_WIDTH +: BLOCK_WIDTH];
            {rippleCarry, sumBlk} = {1'b0, aBlk} + {1'b0, nbBlk}
                                  + {{BLOCK_WIDTH{1'b0}}, cIn};
            // All bits propagate: the block is transparent to the carry.
            cOut     = (&(aBlk ^ nbBlk)) ? cIn : rippleCarry;
            diffNext = diffIn;
            diffNext[k*BLOCK_WIDTH +: BLOCK_WIDTH] = sumBlk;
        end

        always_ff @(posedge iClk or negedge iRstn) begin
            if (!iRstn) begin
                validQ[k] <= 1'b0;
                carryQ[k] <= 1'b1;  // reads as borrow-out 0 at the output
                diffQ[k]  <= '0;
                aQ[k]     <= '0;
                nbQ[k]    <= '0;
            end else if (adv[k]) begin
                validQ[k] <= vIn;
                carryQ[k] <= cOut;
                diffQ[k]  <= diffNext;
                aQ[k]     <= aIn;
                nbQ[k]    <= nbIn;
            end
        end

`ifdef PIPELINED_BYPASS_SUBTRACTOR_OVERFLOW_EN
        if (k == STAGES - 1) begin : gOvf
            logic ovfQ;

            // Operand signs differ (A msb != B msb, i.e. A msb == ~B msb) and
            // the result sign differs from A.
            always_ff @(posedge iClk or negedge iRstn) begin
                if (!iRstn) begin
                    ovfQ <= 1'b0;
                end else if (adv[k]) begin
                    ovfQ <= (aIn[MSB] == nbIn[MSB]) & (diffNext[MSB] != aIn[MSB]);
                end
            end

            assign bus.oOverflow = ovfQ;
        end
`endif
    end

    assign bus.oReady  = adv[0];
    assign bus.oValid  = validQ[STAGES-1];
    assign bus.oDiff   = diffQ[STAGES-1];
    assign bus.oBorrow = ~carryQ[STAGES-1];

endmodule

// File: tb/tb_pipelined_bypass_subtractor.sv
// Directed self-checking bench for pipelined_bypass_subtractor (32-bit, 4 stages).
// Inputs are driven at the falling edge; outputs are sampled 1 ns later.
module tb_pipelined_bypass_subtractor;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    pipelined_bypass_subtractor_if #(.ADDER_WIDTH(32)) bus ();

    pipelined_bypass_subtractor #(
        .ADDER_WIDTH(32),
        .BLOCK_WIDTH(8)
    ) dut (
        .iClk (clk),
        .iRstn(rstn),
        .bus  (bus)
    );

    int cmpCnt = 0;
    int errCnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat with iReady=1; called at a falling edge.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic [31:0] expDiff, input logic expBor);
        bus.iA      = a;
        bus.iB      = b;
        bus.iBorrow = br;
        bus.iValid  = 1'b1;
        bus.iReady  = 1'b1;
        #1;
        check($sformatf("%s.ready", tag), bus.oReady, 1);
        @(negedge clk);  // accept edge has passed
        bus.iValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("%s.early", tag), bus.oValid, 0);
        @(negedge clk);  // fourth rising edge since drive
        check($sformatf("%s.valid", tag), bus.oValid, 1);
        check($sformatf("%s.diff", tag), bus.oDiff, expDiff);
        check($sformatf("%s.borrow", tag), bus.oBorrow, expBor);
`ifdef PIPELINED_BYPASS_SUBTRACTOR_OVERFLOW_EN
        check($sformatf("%s.ovf", tag), bus.oOverflow,
              (a[31] != b[31]) && (expDiff[31] != a[31]));
`endif
        @(negedge clk);
        check($sformatf("%s.nodup", tag), bus.oValid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin
        int nextIn;
        int nextOut;
        int firstOut;
        int lastOut;
        logic [32:0] expQ[$];
        logic [32:0] e;

        bus.iValid  = 1'b0;
        bus.iA      = '0;
        bus.iB      = '0;
        bus.iBorrow = 1'b0;
        bus.iReady  = 1'b1;
        rstn        = 1'b1;
        #1 rstn     = 1'b0;
        #1;
        check("rst.valid", bus.oValid, 0);
        check("rst.diff", bus.oDiff, 0);
        check("rst.borrow", bus.oBorrow, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst.ready", bus.oReady, 1);
        @(negedge clk);

        // Directed single beats.
        single("s5m3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0);
        single("s3m5", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1);
        single("s0m0b", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        single("bypass", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0);
        single("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0);
        single("wrap", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1);

        // Ten beats A=7i, B=i with the consumer stalled in cycles 3..8.
        nextIn  = 0;
        nextOut = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.iReady = !(cyc >= 3 && cyc <= 8);
            if (nextIn < 10) begin
                bus.iValid  = 1'b1;
                bus.iA      = 32'(nextIn * 7);
                bus.iB      = 32'(nextIn);
                bus.iBorrow = 1'b0;
            end else begin
                bus.iValid = 1'b0;
            end
            #1;
            if (nextIn < 10)
                check($sformatf("stall.ready%0d", cyc), bus.oReady, !(cyc >= 4 && cyc <= 8));
            if (cyc >= 4 && cyc <= 8) begin
                check($sformatf("stall.hold_valid%0d", cyc), bus.oValid, 1);
                check($sformatf("stall.hold_diff%0d", cyc), bus.oDiff, 32'(nextOut * 6));
            end
            if (bus.oValid && bus.iReady) begin
                check($sformatf("stall.diff%0d", nextOut), bus.oDiff, 32'(nextOut * 6));
                check($sformatf("stall.borrow%0d", nextOut), bus.oBorrow, 0);
                nextOut++;
            end
            if (bus.iValid && bus.oReady) nextIn++;
            @(negedge clk);
        end
        check("stall.in_count", 64'(nextIn), 10);
        check("stall.out_count", 64'(nextOut), 10);
        check("stall.drained", bus.oValid, 0);

        // Back-to-back stream with a ready consumer.
        nextIn   = 0;
        nextOut  = 0;
        firstOut = -1;
        lastOut  = -1;
        bus.iReady = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (nextIn < 8) begin
                bus.iValid  = 1'b1;
                bus.iA      = 32'h1234_0000 + 32'(nextIn) * 32'h0101_0101;
                bus.iB      = 32'(nextIn * 3);
                bus.iBorrow = nextIn[0];
            end else begin
                bus.iValid = 1'b0;
            end
            #1;
            if (nextIn < 8) check($sformatf("b2b.ready%0d", cyc), bus.oReady, 1);
            if (nextOut < 8) begin
                if (bus.oValid) begin
                    if (firstOut < 0) firstOut = cyc;
                    lastOut = cyc;
                    check($sformatf("b2b.diff%0d", nextOut), bus.oDiff, expQ[nextOut][31:0]);
                    check($sformatf("b2b.borrow%0d", nextOut), bus.oBorrow, expQ[nextOut][32]);
                    nextOut++;
                end
            end else begin
                check($sformatf("b2b.extra%0d", cyc), bus.oValid, 0);
            end
            if (bus.iValid && bus.oReady) begin
                e = {1'b0, bus.iA} - {1'b0, bus.iB} - 33'(bus.iBorrow);
                expQ.push_back(e);
                nextIn++;
            end
            @(negedge clk);
        end
        check("b2b.out_count", 64'(nextOut), 8);
        check("b2b.first", 64'(firstOut), 4);
        check("b2b.last", 64'(lastOut), 11);

        // Fill the pipeline against a stalled consumer, then reset mid-cycle.
        bus.iReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.iValid  = 1'b1;
            bus.iA      = (i == 0) ? 32'd1 : 32'(i + 100);
            bus.iB      = (i == 0) ? 32'd2 : 32'(i);
            bus.iBorrow = 1'b0;
            @(negedge clk);
        end
        bus.iValid = 1'b0;
        #1;
        check("pre_rst.valid", bus.oValid, 1);
        check("pre_rst.diff", bus.oDiff, 32'hFFFF_FFFF);
        check("pre_rst.borrow", bus.oBorrow, 1);
        #1 rstn = 1'b0;
        #1;
        check("async_rst.valid", bus.oValid, 0);
        check("async_rst.diff", bus.oDiff, 0);
        check("async_rst.borrow", bus.oBorrow, 0);
`ifdef PIPELINED_BYPASS_SUBTRACTOR_OVERFLOW_EN
        check("async_rst.ovf", bus.oOverflow, 0);
`endif
        @(negedge clk);
        bus.iReady = 1'b1;
        rstn       = 1'b1;
        #1;
        check("post_rst.ready", bus.oReady, 1);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_rst.no_stale%0d", cyc), bus.oValid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
